// File: rtl/misc_exec_pipe.sv
// misc_exec_pipe: execute pipe for miscellaneous ops (branch-and-link
// writeback, CSR read / write / exchange, other privileged ops).
// One op lives in the execute (E) stage at a time. Privileged ops wait
// there until they reach the ROB head, then CSR ops run a req/ack read.
// Each finished op moves into an elastic chain of STAGES result registers
// that feeds commit.
module misc_exec_pipe #(
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 6,
    parameter int PDEST_W = 6,
    parameter int CSR_AW  = 14,
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         in_op_i,
    input  logic               in_link_i,
    input  logic [DATA_W-1:0]  in_pc_i,
    input  logic [DATA_W-1:0]  in_src0_i,
    input  logic [DATA_W-1:0]  in_src1_i,
    input  logic [DATA_W-1:0]  in_imm_i,
    input  logic [PDEST_W-1:0] in_pdest_i,
    input  logic [ROB_W-1:0]   in_rob_idx_i,
    input  logic [ROB_W-1:0]   oldest_rob_idx_i,
    output logic               csr_req_o,
    output logic [CSR_AW-1:0]  csr_addr_o,
    input  logic               csr_ack_i,
    input  logic [DATA_W-1:0]  csr_rdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_we_o,
    output logic [DATA_W-1:0]  out_wdata_o,
    output logic [PDEST_W-1:0] out_pdest_o,
    output logic [ROB_W-1:0]   out_rob_idx_o,
    output logic [2:0]         out_op_o,
    output logic               out_csr_we_o,
    output logic [CSR_AW-1:0]  out_csr_waddr_o,
    output logic [DATA_W-1:0]  out_csr_wdata_o
);

    localparam logic [2:0] OP_BR      = 3'd0;
    localparam logic [2:0] OP_CSR_RD  = 3'd1;
    localparam logic [2:0] OP_CSR_WR  = 3'd2;
    localparam logic [2:0] OP_CSR_XCH = 3'd3;
    localparam logic [2:0] OP_PRIV    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OLD,
        CSR_WAIT,
        DONE
    } e_state_t;

    typedef struct packed {
        logic               we;
        logic [DATA_W-1:0]  wdata;
        logic [PDEST_W-1:0] pdest;
        logic [ROB_W-1:0]   rob;
        logic [2:0]         op;
        logic               csr_we;
        logic [CSR_AW-1:0]  csr_waddr;
        logic [DATA_W-1:0]  csr_wdata;
    } res_t;

    // Op codes 5..7 behave exactly like PRIV_OTHER.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op > OP_PRIV) ? OP_PRIV : op;
    endfunction

    // Stage k can take a new entry unless it and every stage after it
    // are full while commit is stalling; written as a closed form so
    // there is no combinational chain through the ready vector.
    function automatic logic stage_ready(input int k,
                                         input logic [STAGES-1:0] v,
                                         input logic rdy);
        logic [STAGES-1:0] below;
        below = '0;
        for (int j = 0; j < STAGES; j++) begin
            below[j] = (j < k);
        end
        return rdy | ~(&(v | below));
    endfunction

    e_state_t           state;
    logic [2:0]         e_op;
    logic               e_link;
    logic [DATA_W-1:0]  e_pc;
    logic [DATA_W-1:0]  e_src0;
    logic [DATA_W-1:0]  e_src1;
    logic [CSR_AW-1:0]  e_csr_addr;
    logic [PDEST_W-1:0] e_pdest;
    logic [ROB_W-1:0]   e_rob;
    logic [DATA_W-1:0]  e_rdata;
    logic [2:0]         e_kind;
    res_t               e_result;

    logic [STAGES-1:0]  stg_valid;
    logic [STAGES-1:0]  stg_ready;
    res_t               stg_data [STAGES];

    logic               accept;
    logic               unused_imm_hi;

    assign e_kind        = norm_op(e_op);
    assign unused_imm_hi = &{1'b0, in_imm_i[DATA_W-1:CSR_AW]};

    for (genvar k = 0; k < STAGES; k++) begin : g_ready
        assign stg_ready[k] = stage_ready(k, stg_valid, out_ready_i);
    end

    assign in_ready_o = ~rst & ~flush_i &
                        ((state == IDLE) | ((state == DONE) & stg_ready[0]));
    assign accept     = in_valid_i & in_ready_o;

    assign csr_req_o  = (state == CSR_WAIT);
    assign csr_addr_o = csr_req_o ? e_csr_addr : '0;

    // Execute-stage FSM: capture an accepted op, hold priv ops until they
    // reach the ROB head, run the CSR read handshake, then hand off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            e_op       <= '0;
            e_link     <= 1'b0;
            e_pc       <= '0;
            e_src0     <= '0;
            e_src1     <= '0;
            e_csr_addr <= '0;
            e_pdest    <= '0;
            e_rob      <= '0;
            e_rdata    <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else if (accept) begin
            e_op       <= in_op_i;
            e_link     <= in_link_i;
            e_pc       <= in_pc_i;
            e_src0     <= in_src0_i;
            e_src1     <= in_src1_i;
            e_csr_addr <= in_imm_i[CSR_AW-1:0];
            e_pdest    <= in_pdest_i;
            e_rob      <= in_rob_idx_i;
            e_rdata    <= '0;
            state      <= (norm_op(in_op_i) == OP_BR) ? DONE : WAIT_OLD;
        end else begin
            case (state)
                WAIT_OLD: begin
                    if (e_rob == oldest_rob_idx_i) begin
                        state <= (e_kind == OP_PRIV) ? DONE : CSR_WAIT;
                    end
                end
                CSR_WAIT: begin
                    if (csr_ack_i) begin
                        e_rdata <= csr_rdata_i;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (stg_ready[0]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Build the commit record for the op currently finishing in E.
    always_comb begin
        e_result       = '0;
        e_result.pdest = e_pdest;
        e_result.rob   = e_rob;
        e_result.op    = e_op;
        case (e_kind)
            OP_BR: begin
                e_result.we    = e_link;
                e_result.wdata = e_pc + DATA_W'(4);
            end
            OP_CSR_RD: begin
                e_result.we    = 1'b1;
                e_result.wdata = e_rdata;
            end
            OP_CSR_WR: begin
                e_result.we        = 1'b1;
                e_result.wdata     = e_rdata;
                e_result.csr_we    = 1'b1;
                e_result.csr_waddr = e_csr_addr;
                e_result.csr_wdata = e_src0;
            end
            OP_CSR_XCH: begin
                e_result.we        = 1'b1;
                e_result.wdata     = e_rdata;
                e_result.csr_we    = 1'b1;
                e_result.csr_waddr = e_csr_addr;
                e_result.csr_wdata = (e_rdata & ~e_src1) | (e_src0 & e_src1);
            end
            default: begin
                e_result.we     = 1'b0;
                e_result.csr_we = 1'b0;
            end
        endcase
    end

    // Elastic result chain: each stage loads from its predecessor whenever
    // it is ready, so a stalled commit backs the pipe up without losing ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_data[k] <= '0;
            end
        end else if (flush_i) begin
            stg_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            if (stg_ready[0]) begin
                stg_valid[0] <= (state == DONE);
                if (state == DONE) begin
                    stg_data[0] <= e_result;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (stg_ready[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_data[k] <= stg_data[k-1];
                    end
                end
            end
        end
    end

    assign out_valid_o     = stg_valid[STAGES-1];
    assign out_we_o        = stg_data[STAGES-1].we;
    assign out_wdata_o     = stg_data[STAGES-1].wdata;
    assign out_pdest_o     = stg_data[STAGES-1].pdest;
    assign out_rob_idx_o   = stg_data[STAGES-1].rob;
    assign out_op_o        = stg_data[STAGES-1].op;
    assign out_csr_we_o    = stg_data[STAGES-1].csr_we;
    assign out_csr_waddr_o = stg_data[STAGES-1].csr_waddr;
    assign out_csr_wdata_o = stg_data[STAGES-1].csr_wdata;

endmodule

// File: tb/tb_misc_exec_pipe.sv
// tb_misc_exec_pipe: directed stimulus with a scoreboard for the misc
// execute pipe. Issued ops push their hand-computed result into a queue;
// a negedge monitor pops and compares every result commit accepts.
module tb_misc_exec_pipe;

    localparam int DATA_W  = 32;
    localparam int ROB_W   = 6;
    localparam int PDEST_W = 6;
    localparam int CSR_AW  = 14;
    localparam int STAGES  = 2;

    logic               clk;
    logic               rst;
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [2:0]         in_op_i;
    logic               in_link_i;
    logic [DATA_W-1:0]  in_pc_i;
    logic [DATA_W-1:0]  in_src0_i;
    logic [DATA_W-1:0]  in_src1_i;
    logic [DATA_W-1:0]  in_imm_i;
    logic [PDEST_W-1:0] in_pdest_i;
    logic [ROB_W-1:0]   in_rob_idx_i;
    logic [ROB_W-1:0]   oldest_rob_idx_i;
    logic               csr_req_o;
    logic [CSR_AW-1:0]  csr_addr_o;
    logic               csr_ack_i;
    logic [DATA_W-1:0]  csr_rdata_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               out_we_o;
    logic [DATA_W-1:0]  out_wdata_o;
    logic [PDEST_W-1:0] out_pdest_o;
    logic [ROB_W-1:0]   out_rob_idx_o;
    logic [2:0]         out_op_o;
    logic               out_csr_we_o;
    logic [CSR_AW-1:0]  out_csr_waddr_o;
    logic [DATA_W-1:0]  out_csr_wdata_o;

    typedef struct {
        logic [2:0]  op;
        logic        link;
        logic [31:0] pc;
        logic [31:0] src0;
        logic [31:0] src1;
        logic [31:0] imm;
        logic [5:0]  pdest;
        logic [5:0]  rob;
        logic        we;
        logic [31:0] wdata;
        logic        csr_we;
        logic [13:0] csr_waddr;
        logic [31:0] csr_wdata;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic        held;
    logic [16:0] held_ctl;
    logic [31:0] held_wdata;
    logic [31:0] held_cwdata;
    logic [13:0] held_caddr;

    misc_exec_pipe #(
        .DATA_W (DATA_W),
        .ROB_W  (ROB_W),
        .PDEST_W(PDEST_W),
        .CSR_AW (CSR_AW),
        .STAGES (STAGES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_op_i         (in_op_i),
        .in_link_i       (in_link_i),
        .in_pc_i         (in_pc_i),
        .in_src0_i       (in_src0_i),
        .in_src1_i       (in_src1_i),
        .in_imm_i        (in_imm_i),
        .in_pdest_i      (in_pdest_i),
        .in_rob_idx_i    (in_rob_idx_i),
        .oldest_rob_idx_i(oldest_rob_idx_i),
        .csr_req_o       (csr_req_o),
        .csr_addr_o      (csr_addr_o),
        .csr_ack_i       (csr_ack_i),
        .csr_rdata_i     (csr_rdata_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_we_o        (out_we_o),
        .out_wdata_o     (out_wdata_o),
        .out_pdest_o     (out_pdest_o),
        .out_rob_idx_o   (out_rob_idx_o),
        .out_op_o        (out_op_o),
        .out_csr_we_o    (out_csr_we_o),
        .out_csr_waddr_o (out_csr_waddr_o),
        .out_csr_wdata_o (out_csr_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [2:0] op, input logic link,
                                   input logic [31:0] pc, input logic [31:0] src0,
                                   input logic [31:0] src1, input logic [31:0] imm,
                                   input logic [5:0] pdest, input logic [5:0] rob,
                                   input logic we, input logic [31:0] wdata,
                                   input logic csr_we, input logic [13:0] csr_waddr,
                                   input logic [31:0] csr_wdata);
        vec_t v;
        v.op = op; v.link = link; v.pc = pc; v.src0 = src0; v.src1 = src1;
        v.imm = imm; v.pdest = pdest; v.rob = rob; v.we = we; v.wdata = wdata;
        v.csr_we = csr_we; v.csr_waddr = csr_waddr; v.csr_wdata = csr_wdata;
        return v;
    endfunction

    // Present one op until it is accepted (or the bound runs out) and
    // queue its expected result on acceptance.
    task automatic applyStimulus(input vec_t v, input int bound, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        in_op_i = v.op; in_link_i = v.link; in_pc_i = v.pc;
        in_src0_i = v.src0; in_src1_i = v.src1; in_imm_i = v.imm;
        in_pdest_i = v.pdest; in_rob_idx_i = v.rob;
        in_valid_i = 1'b1;
        while (!acc && waits < bound) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            waits++;
        end
        in_valid_i = 1'b0;
        if (acc) begin
            sb.push_back(v);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within %0d cycles", bound);
        end
    endtask

    // Wait until every queued result has come out.
    task automatic drainPipe(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drain"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a CSR request; returns at a negedge.
    task automatic waitReq(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!csr_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_req"}, {31'd0, csr_req_o}, 1);
    endtask

    // Monitor: compare every accepted result against the scoreboard and
    // check that a stalled result holds still.
    always @(negedge clk) begin
        if (rst || flush_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("stall_valid", {31'd0, out_valid_o}, 1);
                checkOutput("stall_ctl", {15'd0, out_we_o, out_pdest_o, out_rob_idx_o, out_op_o, out_csr_we_o}, {15'd0, held_ctl});
                checkOutput("stall_wdata", out_wdata_o, held_wdata);
                checkOutput("stall_csr", {out_csr_wdata_o ^ held_cwdata}, {18'd0, out_csr_waddr_o ^ held_caddr});
            end
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got rob %0d, expected no result", out_rob_idx_o);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    checkOutput("out_we", {31'd0, out_we_o}, {31'd0, e.we});
                    if (e.we) checkOutput("out_wdata", out_wdata_o, e.wdata);
                    checkOutput("out_pdest", {26'd0, out_pdest_o}, {26'd0, e.pdest});
                    checkOutput("out_rob", {26'd0, out_rob_idx_o}, {26'd0, e.rob});
                    checkOutput("out_op", {29'd0, out_op_o}, {29'd0, e.op});
                    checkOutput("out_csr_we", {31'd0, out_csr_we_o}, {31'd0, e.csr_we});
                    if (e.csr_we) begin
                        checkOutput("out_csr_waddr", {18'd0, out_csr_waddr_o}, {18'd0, e.csr_waddr});
                        checkOutput("out_csr_wdata", out_csr_wdata_o, e.csr_wdata);
                    end
                end
            end
            held        = out_valid_o && !out_ready_i;
            held_ctl    = {out_we_o, out_pdest_o, out_rob_idx_o, out_op_o, out_csr_we_o};
            held_wdata  = out_wdata_o;
            held_cwdata = out_csr_wdata_o;
            held_caddr  = out_csr_waddr_o;
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed test sequence.
    initial begin
        vec_t v;
        int   w;
        int   total;
        int   n;

        held = 1'b0;
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_op_i = '0;
        in_link_i = 1'b0; in_pc_i = '0; in_src0_i = '0; in_src1_i = '0;
        in_imm_i = '0; in_pdest_i = '0; in_rob_idx_i = '0;
        oldest_rob_idx_i = '0; csr_ack_i = 1'b0; csr_rdata_i = '0;
        out_ready_i = 1'b1;

        #2;
        checkOutput("reset_out_valid", {31'd0, out_valid_o}, 0);
        checkOutput("reset_csr_req", {31'd0, csr_req_o}, 0);
        checkOutput("reset_in_ready", {31'd0, in_ready_o}, 0);
        checkOutput("reset_wdata", out_wdata_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: single BR latency, then back-to-back BRs.
        v = mkVec(3'd0, 1'b1, 32'h1000, 0, 0, 0, 6'd5, 6'd0, 1'b1, 32'h1004, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (out_valid_o) break;
        end
        checkOutput("br_latency", n, 3);
        drainPipe("t1a");

        total = 0;
        v = mkVec(3'd0, 1'b1, 32'h2000, 0, 0, 0, 6'd6, 6'd1, 1'b1, 32'h2004, 1'b0, 0, 0);
        applyStimulus(v, 10, w); total += w;
        v = mkVec(3'd0, 1'b0, 32'h2010, 0, 0, 0, 6'd7, 6'd2, 1'b0, 32'h2014, 1'b0, 0, 0);
        applyStimulus(v, 10, w); total += w;
        v = mkVec(3'd0, 1'b1, 32'hFFFF_FFFC, 0, 0, 0, 6'd8, 6'd3, 1'b1, 32'h0, 1'b0, 0, 0);
        applyStimulus(v, 10, w); total += w;
        v = mkVec(3'd0, 1'b1, 32'h3000, 0, 0, 0, 6'd9, 6'd4, 1'b1, 32'h3004, 1'b0, 0, 0);
        applyStimulus(v, 10, w); total += w;
        checkOutput("br_throughput", total, 4);
        drainPipe("t1b");

        // Test 2: CSR_XCHG waits for ROB head; stray ack ignored.
        oldest_rob_idx_i = 6'd1;
        v = mkVec(3'd3, 1'b0, 32'h4000, 32'h1234, 32'h00FF, 32'h0000_0300, 6'd10, 6'd3,
                  1'b1, 32'hFFFF_0000, 1'b1, 14'h300, 32'hFFFF_0034);
        applyStimulus(v, 10, w);
        for (int i = 0; i < 4; i++) begin
            csr_ack_i   = (i == 1);
            csr_rdata_i = (i == 1) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            checkOutput("wait_no_req", {31'd0, csr_req_o}, 0);
            @(posedge clk);
            #1;
        end
        csr_ack_i = 1'b0; csr_rdata_i = '0;
        oldest_rob_idx_i = 6'd3;
        waitReq("t2");
        checkOutput("t2_addr", {18'd0, csr_addr_o}, 32'h300);
        csr_ack_i = 1'b1; csr_rdata_i = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        csr_ack_i = 1'b0; csr_rdata_i = '0;
        drainPipe("t2");

        // Test 3: CSR_RD with ack delayed 5 cycles; address truncation.
        oldest_rob_idx_i = 6'd5;
        v = mkVec(3'd1, 1'b0, 32'h4100, 0, 0, 32'hFFFF_C123, 6'd11, 6'd5,
                  1'b1, 32'hA5A5_5A5A, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        waitReq("t3");
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_req", {31'd0, csr_req_o}, 1);
            checkOutput("hold_addr", {18'd0, csr_addr_o}, 32'h0123);
            checkOutput("hold_in_ready", {31'd0, in_ready_o}, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        csr_ack_i = 1'b1; csr_rdata_i = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        csr_ack_i = 1'b0; csr_rdata_i = '0;
        @(negedge clk);
        checkOutput("ready_after_done", {31'd0, in_ready_o}, 1);
        drainPipe("t3");

        // CSR_WR with ack in the first request cycle, then PRIV ops 4 and 6.
        oldest_rob_idx_i = 6'd6;
        v = mkVec(3'd2, 1'b0, 32'h4200, 32'hCAFE_F00D, 32'h0, 32'h0000_0005, 6'd12, 6'd6,
                  1'b1, 32'h0000_0011, 1'b1, 14'h005, 32'hCAFE_F00D);
        applyStimulus(v, 10, w);
        waitReq("wr");
        csr_ack_i = 1'b1; csr_rdata_i = 32'h0000_0011;
        @(posedge clk);
        #1;
        csr_ack_i = 1'b0; csr_rdata_i = '0;
        drainPipe("wr");

        oldest_rob_idx_i = 6'd7;
        v = mkVec(3'd4, 1'b1, 32'h4300, 0, 0, 0, 6'd13, 6'd7, 1'b0, 0, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        drainPipe("priv4");
        oldest_rob_idx_i = 6'd8;
        v = mkVec(3'd6, 1'b1, 32'h4400, 0, 0, 0, 6'd14, 6'd8, 1'b0, 0, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        drainPipe("priv6");

        // Test 4: commit stalls 6 cycles while 4 BRs are offered.
        out_ready_i = 1'b0;
        v = mkVec(3'd0, 1'b1, 32'h5000, 0, 0, 0, 6'd15, 6'd10, 1'b1, 32'h5004, 1'b0, 0, 0);
        applyStimulus(v, 2, w);
        v = mkVec(3'd0, 1'b1, 32'h5004, 0, 0, 0, 6'd16, 6'd11, 1'b1, 32'h5008, 1'b0, 0, 0);
        applyStimulus(v, 2, w);
        v = mkVec(3'd0, 1'b1, 32'h5008, 0, 0, 0, 6'd17, 6'd12, 1'b1, 32'h500C, 1'b0, 0, 0);
        applyStimulus(v, 2, w);
        in_op_i = 3'd0; in_link_i = 1'b1; in_pc_i = 32'h500C; in_pdest_i = 6'd18;
        in_rob_idx_i = 6'd13; in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("full_in_ready", {31'd0, in_ready_o}, 0);
            checkOutput("full_out_valid", {31'd0, out_valid_o}, 1);
            @(posedge clk);
            #1;
        end
        out_ready_i = 1'b1;
        v = mkVec(3'd0, 1'b1, 32'h500C, 0, 0, 0, 6'd18, 6'd13, 1'b1, 32'h5010, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        drainPipe("t4");

        // Test 5: flush in the same cycle as the CSR ack.
        oldest_rob_idx_i = 6'd20;
        v = mkVec(3'd1, 1'b0, 32'h4500, 0, 0, 32'h0000_0010, 6'd19, 6'd20, 1'b1, 32'h77, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        waitReq("t5");
        csr_ack_i = 1'b1; csr_rdata_i = 32'h77; flush_i = 1'b1;
        @(posedge clk);
        #1;
        csr_ack_i = 1'b0; csr_rdata_i = '0; flush_i = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("flush_req", {31'd0, csr_req_o}, 0);
        checkOutput("flush_out_valid", {31'd0, out_valid_o}, 0);
        repeat (5) @(negedge clk);
        checkOutput("flush_quiet", {31'd0, out_valid_o}, 0);
        @(posedge clk);
        #1;

        // Test 6: async reset mid CSR wait, then a fresh BR.
        oldest_rob_idx_i = 6'd21;
        v = mkVec(3'd1, 1'b0, 32'h4600, 0, 0, 32'h0000_0020, 6'd20, 6'd21, 1'b1, 32'h0, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        waitReq("t6");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_req", {31'd0, csr_req_o}, 0);
        checkOutput("arst_addr", {18'd0, csr_addr_o}, 0);
        checkOutput("arst_out_valid", {31'd0, out_valid_o}, 0);
        checkOutput("arst_in_ready", {31'd0, in_ready_o}, 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = mkVec(3'd0, 1'b1, 32'h6000, 0, 0, 0, 6'd21, 6'd22, 1'b1, 32'h6004, 1'b0, 0, 0);
        applyStimulus(v, 10, w);
        drainPipe("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
